hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 68 ++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue/hazard bundle between the decode stage and the register scoreboard.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3
);
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs;
  logic [ADDR_W-1:0] issue_rt;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_dst;
  logic [LAT_W-1:0]  issue_lat;
  logic              issue_serial;
  logic              pipe_stall;
  logic              except_m;
  logic              stall_d;
  logic              flush_e;
  logic [ADDR_W:0]   pending_cnt;
  logic              all_clear;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_we, issue_dst, issue_lat,
           issue_serial, pipe_stall, except_m,
    input  stall_d, flush_e, pending_cnt, all_clear
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_we, issue_dst, issue_lat,
           issue_serial, pipe_stall, except_m,
    output stall_d, flush_e, pending_cnt, all_clear
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: holds D while a source is still in flight,
// bubbles E, and drains/clears counters on freeze/exception.
module hazard_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 7
) (
  input  logic               clk,
  input  logic               resetn,
  hazard_scoreboard_if.slave sb
);
  localparam int PCNT_W = ADDR_W + 1;

  // entry 0 exists only so lookups index directly; it is held at zero
  logic [LAT_W-1:0]  r_cnt [REG_NUM];
  logic [LAT_W-1:0]  w_cnt_rs, w_cnt_rt, w_lat_sat;
  logic [PCNT_W-1:0] w_pend;
  logic              w_all_clear, w_haz_rs, w_haz_rt, w_haz_ser;
  logic              w_hold, w_stall_d, w_accept;

  // source lookups; r0 and indices beyond REG_NUM always read as ready
  always_comb begin
    w_cnt_rs = '0;
    w_cnt_rt = '0;
    if (sb.issue_rs != '0 && int'(sb.issue_rs) < REG_NUM) w_cnt_rs = r_cnt[sb.issue_rs];
    if (sb.issue_rt != '0 && int'(sb.issue_rt) < REG_NUM) w_cnt_rt = r_cnt[sb.issue_rt];
  end

  // number of registers still in flight
  always_comb begin
    w_pend = '0;
    for (int r = 1; r < REG_NUM; r++)
      if (r_cnt[r] != '0) w_pend = w_pend + PCNT_W'(1);
  end

  assign w_all_clear = (w_pend == '0);
  assign w_haz_rs    = (w_cnt_rs != '0);
  assign w_haz_rt    = (w_cnt_rt != '0);
  assign w_haz_ser   = sb.issue_serial & ~w_all_clear;
  assign w_hold      = sb.issue_valid & (w_haz_rs | w_haz_rt | w_haz_ser);
  // an exception in M overrides everything: D is redirected, not held
  assign w_stall_d   = (w_hold | sb.pipe_stall) & ~sb.except_m;
  assign w_accept    = sb.issue_valid & sb.issue_we & (sb.issue_dst != '0) &
                       (sb.issue_lat != '0) & ~w_stall_d & ~sb.except_m;
  assign w_lat_sat   = (int'(sb.issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : sb.issue_lat;

  assign sb.stall_d     = w_stall_d;
  assign sb.flush_e     = sb.except_m | (w_hold & ~sb.pipe_stall);
  assign sb.pending_cnt = w_pend;
  assign sb.all_clear   = w_all_clear;

  // counter update: exception clear > load > countdown (frozen under pipe_stall)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (r == 0 || sb.except_m)
          r_cnt[r] <= '0;
        else if (w_accept && int'(sb.issue_dst) == r)
          r_cnt[r] <= w_lat_sat;
        else if (!sb.pipe_stall && r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Two scoreboards (MAX_LAT 7 and 4) share one stimulus stream and are checked
// every cycle against a per-register countdown model, plus directed scenarios.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(3)) sb  ();
  hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(3)) sb4 ();

  assign sb4.issue_valid  = sb.issue_valid;
  assign sb4.issue_rs     = sb.issue_rs;
  assign sb4.issue_rt     = sb.issue_rt;
  assign sb4.issue_we     = sb.issue_we;
  assign sb4.issue_dst    = sb.issue_dst;
  assign sb4.issue_lat    = sb.issue_lat;
  assign sb4.issue_serial = sb.issue_serial;
  assign sb4.pipe_stall   = sb.pipe_stall;
  assign sb4.except_m     = sb.except_m;

  hazard_scoreboard #(.REG_NUM(32), .ADDR_W(5), .LAT_W(3), .MAX_LAT(7))
    dut  (.clk(clk), .resetn(resetn), .sb(sb));
  hazard_scoreboard #(.REG_NUM(32), .ADDR_W(5), .LAT_W(3), .MAX_LAT(4))
    dut4 (.clk(clk), .resetn(resetn), .sb(sb4));

  int total = 0;
  int bad   = 0;
  int mc [2][32];          // model: remaining cycles per register, per build
  int maxl [2] = '{7, 4};
  bit e_st [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit we,
                       input int dst, input int lat, input bit ser,
                       input bit ps, input bit ex);
    sb.issue_valid  = v;
    sb.issue_rs     = 5'(rs);
    sb.issue_rt     = 5'(rt);
    sb.issue_we     = we;
    sb.issue_dst    = 5'(dst);
    sb.issue_lat    = 3'(lat);
    sb.issue_serial = ser;
    sb.pipe_stall   = ps;
    sb.except_m     = ex;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pend(input int k);
    int n = 0;
    for (int r = 1; r < 32; r++) if (mc[k][r] > 0) n++;
    return n;
  endfunction

  // let inputs settle, then compare both DUTs against the model
  task automatic settle();
    int rs, rt, p;
    bit hold, fl;
    #1;
    if (!resetn) for (int k = 0; k < 2; k++) for (int r = 0; r < 32; r++) mc[k][r] = 0;
    rs = int'(sb.issue_rs);
    rt = int'(sb.issue_rt);
    for (int k = 0; k < 2; k++) begin
      p = pend(k);
      hold = sb.issue_valid && ((rs != 0 && mc[k][rs] > 0) || (rt != 0 && mc[k][rt] > 0) ||
                                (sb.issue_serial && p != 0));
      e_st[k] = (hold || sb.pipe_stall) && !sb.except_m;
      fl = sb.except_m || (hold && !sb.pipe_stall);
      if (k == 0) begin
        chk("stall_d L7", int'(sb.stall_d), int'(e_st[k]));
        chk("flush_e L7", int'(sb.flush_e), int'(fl));
        chk("pending L7", int'(sb.pending_cnt), p);
        chk("all_clear L7", int'(sb.all_clear), int'(p == 0));
      end else begin
        chk("stall_d L4", int'(sb4.stall_d), int'(e_st[k]));
        chk("flush_e L4", int'(sb4.flush_e), int'(fl));
        chk("pending L4", int'(sb4.pending_cnt), p);
        chk("all_clear L4", int'(sb4.all_clear), int'(p == 0));
      end
    end
  endtask

  // advance one clock, moving the model by the same rules
  task automatic adv();
    int nx [2][32];
    int dst, lat;
    bit acc;
    dst = int'(sb.issue_dst);
    lat = int'(sb.issue_lat);
    for (int k = 0; k < 2; k++) begin
      acc = sb.issue_valid && sb.issue_we && dst != 0 && lat != 0 && !e_st[k] && !sb.except_m;
      for (int r = 0; r < 32; r++) begin
        if (!resetn || sb.except_m)  nx[k][r] = 0;
        else if (acc && r == dst)    nx[k][r] = (lat > maxl[k]) ? maxl[k] : lat;
        else if (!sb.pipe_stall && mc[k][r] > 0) nx[k][r] = mc[k][r] - 1;
        else                         nx[k][r] = mc[k][r];
      end
    end
    @(posedge clk);
    mc = nx;
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && (pend(0) != 0 || pend(1) != 0); i++) tick();
    chk("drain empty", pend(0) + pend(1), 0);
  endtask

  initial begin
    int n7, n4, ns;
    for (int k = 0; k < 2; k++) for (int r = 0; r < 32; r++) mc[k][r] = 0;
    idle();
    @(negedge clk);
    settle();
    chk("reset pending", int'(sb.pending_cnt), 0);
    chk("reset all_clear", int'(sb.all_clear), 1);
    chk("reset stall_d", int'(sb.stall_d), 0);
    chk("reset flush_e", int'(sb.flush_e), 0);
    adv();
    resetn = 1'b1;
    tick();

    // RAW on r8 after a 3-cycle producer: stalled while cnt is 3,2,1
    drive(1, 0, 0, 1, 8, 3, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8, 0, 0, 0, 0, 0, 0, 0); settle();
      chk("raw8 stall", int'(sb.stall_d), int'(i < 3));
      chk("raw8 flush", int'(sb.flush_e), int'(i < 3));
      adv();
    end
    drain();

    // freeze holds cnt[5]=2, then it counts 2,1,0
    drive(1, 0, 0, 1, 5, 2, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5, 0, 0, 0, 0, 0, 1, 0); settle();
      chk("freeze stall", int'(sb.stall_d), 1);
      chk("freeze pend", int'(sb.pending_cnt), 1);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 0, 0, 0, 0, 0, 0, 0); settle();
      chk("thaw stall", int'(sb.stall_d), int'(i < 2));
      adv();
    end
    drain();

    // exception wipes two pending entries
    drive(1, 0, 0, 1, 3, 4, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 9, 1, 0, 0, 0); tick();
    drive(1, 3, 0, 1, 4, 2, 0, 0, 1); settle();
    chk("exc pend before", int'(sb.pending_cnt), 2);
    chk("exc stall_d", int'(sb.stall_d), 0);
    chk("exc flush_e", int'(sb.flush_e), 1);
    adv();
    idle(); settle();
    chk("exc pend after", int'(sb.pending_cnt), 0);
    chk("exc all_clear", int'(sb.all_clear), 1);
    adv();

    // serializing op waits for an empty board (cnt2 longest: 5 cycles)
    drive(1, 0, 0, 1, 1, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 2, 5, 0, 0, 0); tick();
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 1, 6, 2, 1, 0, 0); settle();
      chk("ser stall vs clear", int'(sb.stall_d), int'(!sb.all_clear));
      if (sb.stall_d) ns++;
      if (!sb.stall_d) begin adv(); break; end
      adv();
    end
    chk("ser stall cycles", ns, 5);
    idle(); settle();
    chk("ser accepted", int'(sb.pending_cnt), 1);
    adv();
    drain();

    // untracked writes, then latency saturation
    drive(1, 0, 0, 1, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0); tick();
    idle(); settle();
    chk("untracked pend", int'(sb.pending_cnt), 0);
    adv();
    drive(1, 0, 0, 1, 4, 7, 0, 0, 0); tick();
    n7 = 0; n4 = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 4, 0, 0, 0, 0, 0, 0, 0); settle();
      if (sb.stall_d) n7++;
      if (sb4.stall_d) n4++;
      adv();
    end
    chk("sat lat L7", n7, 7);
    chk("sat lat L4", n4, 4);
    drain();

    // reload in the cycle the old value would expire
    drive(1, 0, 0, 1, 7, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 7, 3, 0, 0, 0); tick();
    ns = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 7, 0, 0, 0, 0, 0, 0); settle();
      if (sb.stall_d) ns++;
      adv();
    end
    chk("reload stall cycles", ns, 3);
    drain();

    // async reset with 3 pending, then first edge after release accepts
    drive(1, 0, 0, 1, 10, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 11, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 12, 5, 0, 0, 0); tick();
    idle(); settle();
    chk("pre-reset pend", int'(sb.pending_cnt), 3);
    resetn = 1'b0; settle();
    chk("async reset clear", int'(sb.all_clear), 1);
    chk("async reset pend", int'(sb.pending_cnt), 0);
    adv();
    resetn = 1'b1;
    drive(1, 0, 0, 1, 13, 2, 0, 0, 0); tick();
    idle(); settle();
    chk("post-reset accept", int'(sb.pending_cnt), 1);
    adv();

    // randomized traffic on a small register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(9), $urandom_range(9),
            $urandom_range(3) != 0, $urandom_range(9), $urandom_range(7),
            $urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(24) == 0);
      resetn = ($urandom_range(199) != 0);
      tick();
    end
    resetn = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
